divblock: RTL and testbench

//  Iterative restoring divider datapath and control for the multdiv unit; counterpart of the right-shifting Booth product register.

---
 rtl/divblock.sv | 156 +++++++++++++++
 tb/tb_divblock.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/divblock.sv
// divblock: iterative restoring divider, one quotient bit per enabled cycle.
// Ports: clk, clr_n (async low), start/ena in, dividend/divisor in,
//   quotient/remainder/busy/done/dbz registered out.
// Define DIVBLOCK_SIGNED_EN for two's-complement operands (adds FIX state).
module divblock #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             ena,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, nstate;

  logic [2*WIDTH-1:0] rq;
  logic [2*WIDTH-1:0] s;
  logic [2*WIDTH-1:0] stepped;
  logic [WIDTH:0]     t;
  logic [WIDTH-1:0]   dvsr;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [CW-1:0]      cnt;
  logic               dbz_r;
  logic               dz;
  logic               accept;
  logic               last;

`ifdef DIVBLOCK_SIGNED_EN
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;
`endif

  always_comb begin
    dz     = (divisor == '0);
    // busy blocks the single cycle where the FSM sits in
    // DONE but the registered done flag has not risen yet
    accept = ena && start && !busy &&
             (state == IDLE || state == DONE);
    last   = (cnt == CW'(WIDTH-1));
    s      = rq << 1;
    t      = {1'b0, s[2*WIDTH-1:WIDTH]} - {1'b0, dvsr};
    // t[WIDTH] set means the trial subtract borrowed
    stepped = t[WIDTH] ? s
            : {t[WIDTH-1:0], s[WIDTH-1:1], 1'b1};
`ifdef DIVBLOCK_SIGNED_EN
    a_mag = dividend[WIDTH-1] ? -dividend : dividend;
    b_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    q_fix = (sa ^ sb) ? -rq[WIDTH-1:0] : rq[WIDTH-1:0];
    r_fix = sa ? -rq[2*WIDTH-1:WIDTH]
               : rq[2*WIDTH-1:WIDTH];
`else
    a_mag = dividend;
    b_mag = divisor;
`endif
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    if (ena) begin
      if (accept) begin
        nstate = dz ? DONE : RUN;
      end else begin
        unique case (state)
          RUN: begin
            if (last) begin
`ifdef DIVBLOCK_SIGNED_EN
              nstate = FIX;
`else
              nstate = DONE;
`endif
            end
          end
          FIX:     nstate = DONE;
          default: nstate = state;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      rq        <= '0;
      dvsr      <= '0;
      cnt       <= '0;
      dbz_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      dbz       <= 1'b0;
`ifdef DIVBLOCK_SIGNED_EN
      sa        <= 1'b0;
      sb        <= 1'b0;
`endif
    end else if (ena) begin
      if (accept) begin
        cnt   <= '0;
        dvsr  <= b_mag;
        dbz_r <= dz;
        busy  <= 1'b1;
        done  <= 1'b0;
        dbz   <= 1'b0;
        // divide by zero skips the iteration entirely
        if (dz) rq <= {dividend, {WIDTH{1'b1}}};
        else    rq <= {{WIDTH{1'b0}}, a_mag};
`ifdef DIVBLOCK_SIGNED_EN
        sa    <= dividend[WIDTH-1];
        sb    <= divisor[WIDTH-1];
`endif
      end else begin
        unique case (state)
          RUN: begin
            rq  <= stepped;
            cnt <= cnt + 1'b1;
          end
`ifdef DIVBLOCK_SIGNED_EN
          FIX: rq <= {r_fix, q_fix};
`endif
          DONE: begin
            quotient  <= rq[WIDTH-1:0];
            remainder <= rq[2*WIDTH-1:WIDTH];
            busy      <= 1'b0;
            done      <= 1'b1;
            dbz       <= dbz_r;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_divblock.sv
// tb_divblock: directed bench for divblock with a latency/arith model.
// Build with DIVBLOCK_SIGNED_EN to also run signed vectors.
module tb_divblock;

  localparam int W = 32;
`ifdef DIVBLOCK_SIGNED_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif

  logic         clk;
  logic         clr_n;
  logic         start;
  logic         ena;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         dbz;

  int tests = 0;
  int fails = 0;

  divblock #(.WIDTH(W)) dut (
    .clk(clk),
    .clr_n(clr_n),
    .start(start),
    .ena(ena),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .dbz(dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [W-1:0] got,
                     input logic [W-1:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  // reference arithmetic from the result rules
  task automatic ref_div(input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         output logic [W-1:0] q,
                         output logic [W-1:0] r,
                         output logic z);
    z = (b == 0);
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
`ifdef DIVBLOCK_SIGNED_EN
      if (a == 32'h8000_0000 && b == '1) begin
        q = a;
        r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endtask

  // model: outputs are a pure function of enabled edges since accept
  int           m_left;
  logic         m_busy, m_done, m_dbz;
  logic [W-1:0] m_q, m_r, p_q, p_r;
  logic         p_z;

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_left = 0;
      m_busy = 0;
      m_done = 0;
      m_dbz  = 0;
      m_q    = '0;
      m_r    = '0;
    end else if (ena) begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 0;
          m_done = 1;
          m_q    = p_q;
          m_r    = p_r;
          m_dbz  = p_z;
        end
      end else if (start) begin
        ref_div(dividend, divisor, p_q, p_r, p_z);
        m_left = p_z ? 1 : LAT;
        m_busy = 1;
        m_done = 0;
        m_dbz  = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (clr_n) begin
      chk("busy", W'(busy), W'(m_busy));
      chk("done", W'(done), W'(m_done));
      chk("dbz", W'(dbz), W'(m_dbz));
      if (m_done) begin
        chk("quot", quotient, m_q);
        chk("rem", remainder, m_r);
      end
    end
  end

  // start a divide and return enabled+stalled edges until done
  task automatic go(input logic [W-1:0] a,
                    input logic [W-1:0] b,
                    input bit stall,
                    output int e);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    ena      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    e = 0;
    while (e < 300) begin
      @(negedge clk);
      if (done) break;
      ena = !(stall && (e == 3 || e == 7 || e == 8 ||
                        e == 15 || e == 20));
      if (stall && e == 10) begin
        start    = 1'b1;
        dividend = 32'd5;
        divisor  = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      e++;
    end
    ena   = 1'b1;
    start = 1'b0;
    chk("timeout", W'(e < 300), 1);
  endtask

  int e;

  initial begin
    clr_n    = 1'b0;
    start    = 1'b0;
    ena      = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_flags", W'({busy, done, dbz}), 0);
    clr_n = 1'b1;

    go(32'd100, 32'd7, 0, e);
    chk("lat_100_7", e, LAT);
    chk("q_100_7", quotient, 14);
    chk("r_100_7", remainder, 2);

    go(32'hFFFF_FFFF, 32'd1, 0, e);
    chk("q_max_1", quotient, 32'hFFFF_FFFF);
    chk("r_max_1", remainder, 0);

    go(32'd5, 32'd9, 0, e);
    chk("q_5_9", quotient, 0);
    chk("r_5_9", remainder, 5);

    go(32'd1234, 32'd0, 0, e);
    chk("lat_dbz", e, 1);
    chk("q_dbz", quotient, 32'hFFFF_FFFF);
    chk("r_dbz", remainder, 1234);
    chk("flag_dbz", W'(dbz), 1);

    go(32'd100, 32'd7, 1, e);
    chk("lat_stall", e, LAT + 5);
    chk("q_stall", quotient, 14);
    chk("r_stall", remainder, 2);

    @(negedge clk);
    ena      = 1'b0;
    start    = 1'b1;
    dividend = 32'd77;
    divisor  = 32'd0;
    @(negedge clk);
    start = 1'b0;
    ena   = 1'b1;
    chk("noacc_done", W'(done), 1);
    chk("noacc_busy", W'(busy), 0);
    chk("noacc_q", quotient, 14);

    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 clr_n = 1'b0;
    #1;
    chk("mid_rst_q", quotient, 0);
    chk("mid_rst_r", remainder, 0);
    chk("mid_rst_fl", W'({busy, done, dbz}), 0);
    @(negedge clk);
    clr_n = 1'b1;

    go(32'd9, 32'd3, 0, e);
    chk("q_9_3", quotient, 3);
    chk("r_9_3", remainder, 0);

`ifdef DIVBLOCK_SIGNED_EN
    go(-32'sd7, 32'd2, 0, e);
    chk("q_m7_2", quotient, 32'hFFFF_FFFD);
    chk("r_m7_2", remainder, 32'hFFFF_FFFF);
    go(32'd7, -32'sd2, 0, e);
    chk("q_7_m2", quotient, 32'hFFFF_FFFD);
    chk("r_7_m2", remainder, 1);
    go(32'h8000_0000, 32'hFFFF_FFFF, 0, e);
    chk("lat_ovf", e, 34);
    chk("q_ovf", quotient, 32'h8000_0000);
    chk("r_ovf", remainder, 0);
    chk("dbz_ovf", W'(dbz), 0);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
